// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO. Shift-add multiply and
// restoring divide on magnitudes, one step per cycle, sign fix-up at the end.
//
// state | meaning
// IDLE  | accepting requests; MTHI/MTLO complete here in one cycle
// MUL   | DWIDTH shift-add steps on {hi,lo} accumulator
// DIV   | DWIDTH restoring-subtract steps on {rem,quot}
// SIGN  | apply result signs and write HI/LO
// DZERO | divide by zero; HI/LO untouched, flags done+div_zero
module mdu_ctrl #(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_i_valid,
  input  logic [2:0]        m_i_op,
  input  logic [DWIDTH-1:0] m_i_data_rs,
  input  logic [DWIDTH-1:0] m_i_data_rt,
  input  logic              m_i_flush,
  output logic              m_o_busy,
  output logic              m_o_done,
  output logic              m_o_div_zero,
  output logic [DWIDTH-1:0] m_o_hi,
  output logic [DWIDTH-1:0] m_o_lo
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_SIGN  = 3'd3,
    S_DZERO = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DWIDTH-1:0]     acc_q, acc_d;
  logic [DWIDTH-1:0]       opnd_q, opnd_d;
  logic                    is_div_q, is_div_d;
  logic                    neg_q_q, neg_q_d;
  logic                    neg_r_q, neg_r_d;
  logic [DWIDTH-1:0]       hi_q, hi_d;
  logic [DWIDTH-1:0]       lo_q, lo_d;
  logic                    done_q, done_d;
  logic                    dz_q, dz_d;

  logic                    op_signed;
  logic [DWIDTH-1:0]       mag_rs, mag_rt;
  logic [DWIDTH:0]         mul_sum;
  logic [DWIDTH:0]         div_rem_sh;
  logic [DWIDTH:0]         div_diff;
  logic [2*DWIDTH-1:0]     prod_fix;
  logic [DWIDTH-1:0]       quot_fix, rem_fix;

  assign op_signed = (m_i_op == 3'd0) || (m_i_op == 3'd2);
  assign mag_rs = (op_signed && m_i_data_rs[DWIDTH-1]) ? -m_i_data_rs : m_i_data_rs;
  assign mag_rt = (op_signed && m_i_data_rt[DWIDTH-1]) ? -m_i_data_rt : m_i_data_rt;

  assign mul_sum    = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(DWIDTH+1){1'b0}});
  // Shifted remainder needs one extra bit; the borrow out of it decides the quotient bit.
  assign div_rem_sh = acc_q[2*DWIDTH-1:DWIDTH-1];
  assign div_diff   = div_rem_sh - {1'b0, opnd_q};

  assign prod_fix = neg_q_q ? -acc_q : acc_q;
  assign quot_fix = neg_q_q ? -acc_q[DWIDTH-1:0] : acc_q[DWIDTH-1:0];
  assign rem_fix  = neg_r_q ? -acc_q[2*DWIDTH-1:DWIDTH] : acc_q[2*DWIDTH-1:DWIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    if (state_q != S_IDLE && m_i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m_i_valid && !m_i_flush) begin
            case (m_i_op)
              3'd0, 3'd1: begin
                state_d  = S_MUL;
                cnt_d    = CNT_W'(DWIDTH);
                opnd_d   = mag_rs;
                acc_d    = {{DWIDTH{1'b0}}, mag_rt};
                is_div_d = 1'b0;
                neg_q_d  = op_signed & (m_i_data_rs[DWIDTH-1] ^ m_i_data_rt[DWIDTH-1]);
                neg_r_d  = 1'b0;
              end
              3'd2, 3'd3: begin
                if (m_i_data_rt == '0) begin
                  state_d = S_DZERO;
                end else begin
                  state_d  = S_DIV;
                  cnt_d    = CNT_W'(DWIDTH);
                  opnd_d   = mag_rt;
                  acc_d    = {{DWIDTH{1'b0}}, mag_rs};
                  is_div_d = 1'b1;
                  neg_q_d  = op_signed & (m_i_data_rs[DWIDTH-1] ^ m_i_data_rt[DWIDTH-1]);
                  neg_r_d  = op_signed & m_i_data_rs[DWIDTH-1];
                end
              end
              3'd4: begin
                hi_d   = m_i_data_rs;
                done_d = 1'b1;
              end
              3'd5: begin
                lo_d   = m_i_data_rs;
                done_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_d = {mul_sum, acc_q[DWIDTH-1:1]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_SIGN;
        end
        S_DIV: begin
          if (!div_diff[DWIDTH])
            acc_d = {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
          else
            acc_d = {div_rem_sh[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_SIGN;
        end
        S_SIGN: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*DWIDTH-1:DWIDTH];
            lo_d = prod_fix[DWIDTH-1:0];
          end
        end
        S_DZERO: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign m_o_busy     = (state_q != S_IDLE);
  assign m_o_done     = done_q;
  assign m_o_div_zero = dz_q;
  assign m_o_hi       = hi_q;
  assign m_o_lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed corner cases plus random ops against a
// wide-integer arithmetic reference model.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_i_valid;
  logic [2:0]  m_i_op;
  logic [31:0] m_i_data_rs;
  logic [31:0] m_i_data_rt;
  logic        m_i_flush;
  logic        m_o_busy;
  logic        m_o_done;
  logic        m_o_div_zero;
  logic [31:0] m_o_hi;
  logic [31:0] m_o_lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_hi, ref_lo;

  mdu_ctrl #(.DWIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_i_valid    (m_i_valid),
    .m_i_op       (m_i_op),
    .m_i_data_rs  (m_i_data_rs),
    .m_i_data_rt  (m_i_data_rt),
    .m_i_flush    (m_i_flush),
    .m_o_busy     (m_o_busy),
    .m_o_done     (m_o_done),
    .m_o_div_zero (m_o_div_zero),
    .m_o_hi       (m_o_hi),
    .m_o_lo       (m_o_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: result of one op from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] nhi, output logic [31:0] nlo,
                       output logic dz, output int lat);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = $signed(rs);
    sb = $signed(rt);
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    nhi = ref_hi;
    nlo = ref_lo;
    dz  = 1'b0;
    lat = 34;
    case (op)
      3'd0: begin sp = sa * sb; nhi = sp[63:32]; nlo = sp[31:0]; end
      3'd1: begin up = ua * ub; nhi = up[63:32]; nlo = up[31:0]; end
      3'd2: begin
        if (rt == 0) begin dz = 1'b1; lat = 2; end
        else begin sp = sa / sb; nlo = sp[31:0]; sp = sa % sb; nhi = sp[31:0]; end
      end
      3'd3: begin
        if (rt == 0) begin dz = 1'b1; lat = 2; end
        else begin up = ua / ub; nlo = up[31:0]; up = ua % ub; nhi = up[31:0]; end
      end
      3'd4: begin nhi = rs; lat = 1; end
      3'd5: begin nlo = rs; lat = 1; end
      default: lat = 0;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] nhi, nlo;
    logic dz;
    int lat, k, busy_cnt;
    model(op, rs, rt, nhi, nlo, dz, lat);
    @(negedge clk);
    m_i_valid = 1'b1; m_i_op = op; m_i_data_rs = rs; m_i_data_rt = rt;
    @(posedge clk);
    #1 m_i_valid = 1'b0;
    if (lat == 0) begin
      repeat (3) begin
        @(negedge clk);
        chk("rsv_done", {63'd0, m_o_done}, 64'd0);
      end
      chk("rsv_busy", {63'd0, m_o_busy}, 64'd0);
      chk("rsv_hilo", {m_o_hi, m_o_lo}, {ref_hi, ref_lo});
      return;
    end
    k = 0;
    busy_cnt = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (m_o_done) break;
      if (m_o_busy) begin
        busy_cnt++;
        // Requests while busy must be ignored.
        m_i_valid   = 1'($urandom_range(0, 1));
        m_i_op      = 3'($urandom_range(0, 5));
        m_i_data_rs = $urandom;
        m_i_data_rt = $urandom;
      end
    end
    m_i_valid = 1'b0;
    chk("latency", 64'(k), 64'(lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
    chk("hi", {32'd0, m_o_hi}, {32'd0, nhi});
    chk("lo", {32'd0, m_o_lo}, {32'd0, nlo});
    chk("div_zero", {63'd0, m_o_div_zero}, {63'd0, dz});
    ref_hi = nhi;
    ref_lo = nlo;
    @(negedge clk);
    chk("done_pulse", {62'd0, m_o_done, m_o_busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    logic [2:0] rop;
    logic [31:0] rrs, rrt;
    rst = 1'b1; m_i_valid = 1'b0; m_i_op = '0; m_i_data_rs = '0;
    m_i_data_rt = '0; m_i_flush = 1'b0;
    ref_hi = '0; ref_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", {m_o_hi, m_o_lo}, 64'd0);
    chk("reset_flags", {61'd0, m_o_busy, m_o_done, m_o_div_zero}, 64'd0);
    rst = 1'b0;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg3x7", {m_o_hi, m_o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max", {m_o_hi, m_o_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg7_2", {m_o_hi, m_o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd7);
    chk("divu_100_7", {m_o_hi, m_o_lo}, 64'h0000_0002_0000_000E);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_m1", {m_o_hi, m_o_lo}, 64'h0000_0000_8000_0000);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd5, 32'd9, 32'd0);
    run_op(3'd2, 32'd123, 32'd0);
    chk("dzero_keep", {m_o_hi, m_o_lo}, 64'h0000_0005_0000_0009);
    run_op(3'd5, 32'h1234, 32'd0);
    chk("mtlo", {32'd0, m_o_lo}, 64'h1234);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1);

    // Flush mid-multiply
    @(negedge clk);
    m_i_valid = 1'b1; m_i_op = 3'd0; m_i_data_rs = 32'd5; m_i_data_rt = 32'd6;
    @(posedge clk);
    #1 m_i_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_pre_busy", {63'd0, m_o_busy}, 64'd1);
    m_i_flush = 1'b1;
    @(posedge clk);
    #1 m_i_flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_o_done || m_o_busy) chk("flush_quiet", {62'd0, m_o_done, m_o_busy}, 64'd0);
    end
    chk("flush_hilo", {m_o_hi, m_o_lo}, {ref_hi, ref_lo});

    // Flush exactly in the sign/write cycle
    @(negedge clk);
    m_i_valid = 1'b1; m_i_op = 3'd1; m_i_data_rs = 32'd77; m_i_data_rt = 32'd3;
    @(posedge clk);
    #1 m_i_valid = 1'b0;
    repeat (33) @(negedge clk);
    chk("sign_busy", {62'd0, m_o_done, m_o_busy}, 64'd1);
    m_i_flush = 1'b1;
    @(posedge clk);
    #1 m_i_flush = 1'b0;
    @(negedge clk);
    chk("sign_flush", {62'd0, m_o_done, m_o_busy}, 64'd0);
    chk("sign_flush_hilo", {m_o_hi, m_o_lo}, {ref_hi, ref_lo});

    // Flush in IDLE blocks MTHI
    @(negedge clk);
    m_i_valid = 1'b1; m_i_op = 3'd4; m_i_data_rs = 32'hCAFE_0001; m_i_flush = 1'b1;
    @(posedge clk);
    #1 begin m_i_valid = 1'b0; m_i_flush = 1'b0; end
    @(negedge clk);
    chk("idle_flush", {m_o_hi, 31'd0, m_o_done}, {ref_hi, 32'd0});

    // Reset mid-divide
    @(negedge clk);
    m_i_valid = 1'b1; m_i_op = 3'd3; m_i_data_rs = 32'd1000; m_i_data_rt = 32'd3;
    @(posedge clk);
    #1 m_i_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_div", {m_o_hi, m_o_lo}, 64'd0);
    chk("rst_mid_flags", {61'd0, m_o_busy, m_o_done, m_o_div_zero}, 64'd0);
    ref_hi = '0; ref_lo = '0;

    for (k = 0; k < 30; k++) begin
      rop = 3'($urandom_range(0, 7));
      rrs = pick_val();
      rrt = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_val();
      run_op(rop, rrs, rrt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide sequencer alongside the single-cycle ALU in the EX stage; owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU in a multi-cycle FSM: one shift-add or restoring-subtract step per cycle.
- Executes MTHI/MTLO in a single cycle.
- Raises busy so the hazard logic stalls the pipeline; supports flush-abort from the pipeline.

Parameters:
- DWIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold DWIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- m_i_valid  input  1  request strobe; sampled only in IDLE.
- m_i_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- m_i_data_rs  input  DWIDTH  multiplicand / dividend / MTHI-MTLO source.
- m_i_data_rt  input  DWIDTH  multiplier / divisor.
- m_i_flush  input  1  abort the current operation; highest priority after rst.
- m_o_busy  output  1  operation in flight; pipeline must stall MFHI/MFLO and any new MDU op.
- m_o_done  output  1  one-cycle pulse; HI/LO updated this cycle.
- m_o_div_zero  output  1  one-cycle pulse with done when the divisor was zero.
- m_o_hi  output  DWIDTH  HI register.
- m_o_lo  output  DWIDTH  LO register.

Behaviour:
- Reset (rst=1 at edge): state IDLE; HI, LO, counter and internal registers = 0; busy = 0, done = 0, div_zero = 0. Reset takes effect in any state, mid-operation included.
- FSM states: IDLE, MUL, DIV, SIGN, DZERO.

IDLE:
- valid=1 and flush=0 at edge T, op 0–3 with a nonzero divisor for div ops:
  - Latch |rs| and |rt|. Signed ops take magnitudes; unsigned ops pass operands through.
  - Record neg_q = rs[MSB]^rt[MSB] (signed only) and neg_r = rs[MSB] (signed div only).
  - Counter = DWIDTH. Go to MUL or DIV. busy=1 from T+1.
- op 4/5 at edge T: HI (op 4) or LO (op 5) = rs at T. done=1 during the T+1 cycle. busy stays 0. No state change.
- op 2/3 with rt==0: go to DZERO. busy=1 at T+1.
- Reserved op: ignored; no outputs change.
- valid while not in IDLE: ignored. The pipeline guarantees the stall.

MUL:
- 2×DWIDTH accumulator, LSB-first shift-add.
- Counter decrements each cycle; DWIDTH cycles, then SIGN.

DIV:
- Restoring division on a {remainder, quotient} shift register, one quotient bit per cycle.
- DWIDTH cycles, then SIGN.

SIGN (1 cycle):
- MUL: negate the 64-bit product if neg_q.
- DIV: negate the quotient if neg_q; negate the remainder if neg_r.
- Write HI/LO at exit:
  - Mul: HI = product[2W-1:W], LO = product[W-1:0].
  - Div: LO = quotient, HI = remainder.
- Return to IDLE.

Done and busy timing:
- In the cycle after SIGN: done=1, busy=0, new HI/LO visible.
- Latency: accept edge T → done high in cycle T+DWIDTH+2 (34 for W=32).
- A new op may be accepted on the edge that ends the done cycle.

DZERO (1 cycle):
- HI/LO unchanged. Then IDLE with done=1 and div_zero=1 together, busy=0.

Flush:
- flush=1 at an edge in any non-IDLE state: go to IDLE, busy=0 next cycle, no done, HI/LO keep pre-op values.
- flush=1 in IDLE: blocks acceptance, including MTHI/MTLO.
- flush in the SIGN state: HI/LO are not written.

Arithmetic:
- All internal arithmetic is unsigned on magnitudes. Negation is two's complement at full width.
- Signed DIV −2^31 / −1: LO=0x80000000, HI=0 (wraps, no exception).
- Remainder sign follows the dividend; quotient truncates toward zero.

Outputs:
- m_o_hi and m_o_lo are register outputs, stable except on write edges.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD (−3), rt=7 → busy for 33 cycles; done at T+34; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; re-issue of valid while busy is ignored.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU rs=100, rt=7 → LO=14, HI=2.
- DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV rt=0 with HI=5, LO=9 preloaded via MTHI/MTLO → done and div_zero pulse together 2 cycles after accept; HI=5, LO=9.
- MULT 5×6 started, flush at cycle 10 → busy drops, no done, HI/LO unchanged.
- rst asserted mid-DIV → all outputs 0 next cycle.
- MTLO rs=0x1234 → LO=0x1234 and done next cycle, busy never high.
